// File: rtl/ual_pkg.sv
// Shared definitions for the UAL accumulator: default widths, opcode map
// and the multiplier sequencer state encoding.
package ual_pkg;

    localparam int UAL_DATA_W = 16;
    localparam int UAL_CNT_W  = 5;

    localparam logic [2:0] OP_NOR  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ual_mul_seq.sv
// Shift-add sequential multiplier. One iteration per ce-qualified edge,
// DATA_W iterations per product. 'fin' is high combinationally during the
// final iteration cycle and 'prod' then carries the finished product, so the
// caller can write it back on that same edge.
module ual_mul_seq
    import ual_pkg::*;
#(
    parameter int DATA_W = UAL_DATA_W,
    parameter int CNT_W  = UAL_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  fin,
    output logic [2*DATA_W-1:0]   prod
);

    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

    mul_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;

    // Next-state: latch operands on start, then one shift-add step per ce edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        fin      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    mcand_d  = {{DATA_W{1'b0}}, a};
                    mplier_d = b;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                if (ce) begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        fin     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any product in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign prod = prod_d;

endmodule

// File: rtl/ual_accumulator.sv
// Accumulator ALU downstream of the R1 operand register. Combines the
// accumulator (operand A) with data_UAL (operand B) under sel_UAL and writes
// the result back, updating carry and zero flags.
// Build option: define UAL_MUL_EN to include the sequential multiplier for
// opcode 111; without it opcode 111 is a NOP that still pulses done.
module ual_accumulator
    import ual_pkg::*;
#(
    parameter int DATA_W = UAL_DATA_W,
    parameter int CNT_W  = UAL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              exec,
    input  logic [2:0]        sel_UAL,
    input  logic              clr_carry,
    input  logic [DATA_W-1:0] data_UAL,
    output logic [DATA_W-1:0] data_accu,
    output logic              carry,
    output logic              zero,
    output logic              busy,
    output logic              done
);

    // The multiplier counter must be able to count DATA_W iterations
    if (!((2 ** CNT_W) > DATA_W)) begin : g_bad_cnt_w
        $error("CNT_W too small for DATA_W");
    end

    logic [DATA_W-1:0]   accu_q, accu_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;

    logic                accept;
    logic                mul_busy;
    logic                mul_fin;
    logic [2*DATA_W-1:0] mul_prod;

    logic [DATA_W-1:0]   result;
    logic [DATA_W:0]     ext;
    logic                res_carry;
    logic                wr;
    logic                nop;

    // An op is taken only when enabled and no multiply is running
    assign accept = exec && ce && !mul_busy;

`ifdef UAL_MUL_EN
    logic mul_start;
    assign mul_start = accept && (sel_UAL == OP_MUL);

    ual_mul_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .start (mul_start),
        .a     (accu_q),
        .b     (data_UAL),
        .busy  (mul_busy),
        .fin   (mul_fin),
        .prod  (mul_prod)
    );
`else
    assign mul_busy = 1'b0;
    assign mul_fin  = 1'b0;
    assign mul_prod = '0;
`endif

    // Result mux, flag update and done generation for every write source
    always_comb begin
        accu_d    = accu_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        result    = '0;
        ext       = '0;
        res_carry = 1'b0;
        wr        = 1'b0;
        nop       = 1'b0;

        if (accept) begin
            case (sel_UAL)
                OP_NOR: begin
                    result = ~(accu_q | data_UAL);
                    wr     = 1'b1;
                end
                OP_ADD: begin
                    ext       = {1'b0, accu_q} + {1'b0, data_UAL};
                    result    = ext[DATA_W-1:0];
                    res_carry = ext[DATA_W];
                    wr        = 1'b1;
                end
                OP_SUB: begin
                    // The extra top bit of the difference is the borrow (A < B)
                    ext       = {1'b0, accu_q} - {1'b0, data_UAL};
                    result    = ext[DATA_W-1:0];
                    res_carry = ext[DATA_W];
                    wr        = 1'b1;
                end
                OP_AND: begin
                    result = accu_q & data_UAL;
                    wr     = 1'b1;
                end
                OP_OR: begin
                    result = accu_q | data_UAL;
                    wr     = 1'b1;
                end
                OP_XOR: begin
                    result = accu_q ^ data_UAL;
                    wr     = 1'b1;
                end
                OP_LOAD: begin
                    result = data_UAL;
                    wr     = 1'b1;
                end
                OP_MUL: begin
`ifndef UAL_MUL_EN
                    nop = 1'b1;
`endif
                end
                default: nop = 1'b1;
            endcase
        end

        // Multiply completion cannot coincide with an accept (busy blocks it)
        if (mul_fin) begin
            result    = mul_prod[DATA_W-1:0];
            res_carry = |mul_prod[2*DATA_W-1:DATA_W];
            wr        = 1'b1;
        end

        if (wr) begin
            accu_d  = result;
            carry_d = res_carry;
            zero_d  = (result == '0);
        end

        // Explicit clear wins over any same-edge carry result
        if (clr_carry && ce) begin
            carry_d = 1'b0;
        end

        done_d = wr || nop;
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            accu_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            accu_q  <= accu_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign data_accu = accu_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign busy      = mul_busy;
    assign done      = done_q;

endmodule
